// File: rtl/allocator_rr.sv
// Round-robin output-port allocator for the butterfly switch, one instance per output port.
// Define ALLOC_MAXLEN_EN to force release of packets longer than MAX_PKT_LEN payload phits.
module allocator_rr #(
   parameter int unsigned N_IN        = 4,
   parameter int unsigned PORT_W      = 2,
   parameter int unsigned TYPE_W      = 2,
   parameter int unsigned HEAD_T      = 3,
   parameter int unsigned PAYLOAD_T   = 2,
   parameter int unsigned MAX_PKT_LEN = 64
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic [PORT_W-1:0]               i_this_port,
   input  logic [N_IN*(TYPE_W+PORT_W)-1:0] i_hdr,
   output logic [N_IN-1:0]                 o_select,
   output logic                            o_shift,
   output logic                            o_busy,
   output logic [$clog2(N_IN)-1:0]         o_owner,
   output logic                            o_err
);

   localparam int unsigned PH_W  = TYPE_W + PORT_W;
   localparam int unsigned IDX_W = $clog2(N_IN);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] grant_idx;
   logic [N_IN-1:0]  head, payload, req, grant, own_oh;
   logic             found, own_pay, forced, hold;
   int unsigned      cand;

   // Per-input phit decode: {type, dest}
   for (genvar k = 0; k < N_IN; k++) begin : g_dec
      logic [PH_W-1:0] phit;
      assign phit       = i_hdr[k*PH_W +: PH_W];
      assign head[k]    = (phit[PH_W-1 -: TYPE_W] == TYPE_W'(HEAD_T));
      assign payload[k] = (phit[PH_W-1 -: TYPE_W] == TYPE_W'(PAYLOAD_T));
      assign req[k]     = head[k] & (phit[PORT_W-1:0] == i_this_port);
   end

   always_comb begin
      own_oh          = '0;
      own_oh[owner_q] = 1'b1;
   end

   assign own_pay = payload[owner_q];
   assign hold    = (state_q == HOLD) & own_pay & ~forced;

`ifdef ALLOC_MAXLEN_EN
   localparam int unsigned CNT_W = $clog2(MAX_PKT_LEN + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Packet has used its payload budget but the owner still sends payload
   assign forced = (state_q == HOLD) & own_pay & (cnt_q == CNT_W'(MAX_PKT_LEN));

   always_comb begin
      cnt_d = cnt_q;
      if (found)
         cnt_d = '0;
      else if (hold)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
`else
   logic unused_maxlen;
   assign unused_maxlen = (MAX_PKT_LEN == 0);
   assign forced        = 1'b0;
`endif

   // Rotating scan starting at ptr_q; disabled while the owner keeps the port
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         cand = 32'(ptr_q) + i;
         if (cand >= N_IN)
            cand = cand - N_IN;
         if (!hold && !found && req[IDX_W'(cand)]) begin
            found                 = 1'b1;
            grant_idx             = IDX_W'(cand);
            grant[IDX_W'(cand)]   = 1'b1;
         end
      end
   end

   // Next state and combinational outputs; release and re-grant share one cycle
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      o_select = '0;
      o_shift  = 1'b0;
      o_err    = 1'b0;
      if (found) begin
         state_d = HOLD;
         owner_d = grant_idx;
         ptr_d   = (grant_idx == IDX_W'(N_IN - 1)) ? '0 : grant_idx + IDX_W'(1);
      end else if (!hold) begin
         state_d = IDLE;
      end
      if (i_rst_n) begin
         o_select = hold ? own_oh : grant;
         o_shift  = found;
         o_err    = forced;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   assign o_busy  = (state_q == HOLD);
   assign o_owner = owner_q;

endmodule
